// File: rtl/dmembus_unaligned_splitter_pkg.sv
// Shared width encodings, splitter states and byte-count helpers.
package dmembus_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b01;
  localparam logic [1:0] WIDTH_HALF = 2'b10;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } split_state_e;

  // Encoded access width to byte count; 00 is treated as a word.
  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  // Byte count (1/2/4) to an LSB-justified data mask.
  function automatic logic [31:0] byte_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/dmembus_unaligned_splitter_if.sv
// Upstream request port plus downstream aligned-membus port of the splitter.
interface dmembus_unaligned_splitter_if;
  // upstream (core side)
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [1:0]  i_width;
  logic        i_we;
  logic        i_re;
  logic        i_zeroextend;
  logic [31:0] o_data;
  logic        o_stall;
  logic        o_error;
  logic        o_unaligned;
  // downstream (aligned membus side)
  logic [31:0] o_m_addr;
  logic [31:0] o_m_data;
  logic [1:0]  o_m_width;
  logic        o_m_we;
  logic        o_m_re;
  logic        o_m_zeroextend;
  logic [31:0] i_m_data;
  logic        i_m_stall;
  logic        i_m_error;

  modport slave (
    input  i_addr, i_data, i_width, i_we, i_re, i_zeroextend,
    output o_data, o_stall, o_error, o_unaligned,
    output o_m_addr, o_m_data, o_m_width, o_m_we, o_m_re, o_m_zeroextend,
    input  i_m_data, i_m_stall, i_m_error
  );

  modport master (
    output i_addr, i_data, i_width, i_we, i_re, i_zeroextend,
    input  o_data, o_stall, o_error, o_unaligned,
    input  o_m_addr, o_m_data, o_m_width, o_m_we, o_m_re, o_m_zeroextend,
    output i_m_data, i_m_stall, i_m_error
  );
endinterface

// File: rtl/dmembus_unaligned_splitter_piece_plan.sv
// Greedy choice of the next aligned piece from the current address LSBs and
// the number of bytes still to transfer.
module dmembus_piece_plan
  import dmembus_pkg::*;
(
  input  logic [1:0] c_lo_i,
  input  logic [2:0] r_i,
  output logic [1:0] width_o,
  output logic [2:0] size_o,
  output logic       last_o
);

  // Largest naturally aligned piece that fits in the remaining bytes.
  always_comb begin
    width_o = WIDTH_BYTE;
    size_o  = 3'd1;
    if (c_lo_i == 2'b00 && r_i >= 3'd4) begin
      width_o = WIDTH_WORD;
      size_o  = 3'd4;
    end else if (!c_lo_i[0] && r_i >= 3'd2) begin
      width_o = WIDTH_HALF;
      size_o  = 3'd2;
    end
    last_o = (size_o >= r_i);
  end

endmodule

// File: rtl/dmembus_unaligned_splitter.sv
// Splits any-alignment loads/stores into aligned membus pieces, merges load
// bytes and applies the final sign/zero extension.
module dmembus_unaligned_splitter
  import dmembus_pkg::*;
#(
  parameter bit ENABLE_SPLIT = 1'b1,
  parameter bit WRAP_ADDR    = 1'b1
) (
  input logic                          i_clk,
  input logic                          i_rst,
  dmembus_unaligned_splitter_if.slave  bus
);

  split_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  k_q, k_d;
  logic        we_q, we_d;
  logic        zext_q, zext_d;
  logic [31:0] merge_q, merge_d;
  logic        seen_q, seen_d;
  logic        err_q, err_d;
  logic        unal_q, unal_d;
  logic [31:0] rdata_q, rdata_d;

  logic [2:0]  req_n;
  logic        misaligned;
  logic [32:0] end_sum;
  logic        reject;
  logic [31:0] cur_addr;
  logic [2:0]  remain;
  logic [1:0]  plan_width;
  logic [2:0]  plan_size;
  logic        plan_last;
  logic [4:0]  shamt;
  logic [31:0] piece_mask;
  logic [31:0] resp_merge;
  logic [31:0] final_val;
  logic        sign_bit;

  dmembus_piece_plan u_plan (
    .c_lo_i  (cur_addr[1:0]),
    .r_i     (remain),
    .width_o (plan_width),
    .size_o  (plan_size),
    .last_o  (plan_last)
  );

  // Request classification and per-piece datapath.
  always_comb begin
    req_n      = width_bytes(bus.i_width);
    misaligned = (req_n == 3'd2 && bus.i_addr[0]) ||
                 (req_n == 3'd4 && bus.i_addr[1:0] != 2'b00);
    end_sum    = {1'b0, bus.i_addr} + {30'd0, req_n} - 33'd1;
    reject     = misaligned && (!ENABLE_SPLIT || (!WRAP_ADDR && end_sum[32]));

    cur_addr   = addr_q + {29'd0, k_q};
    remain     = n_q - k_q;
    shamt      = {k_q[1:0], 3'b000};
    piece_mask = byte_mask(plan_size);
    resp_merge = merge_q | ((bus.i_m_data & piece_mask) << shamt);

    final_val  = resp_merge & byte_mask(n_q);
    case (n_q)
      3'd1:    sign_bit = final_val[7];
      3'd2:    sign_bit = final_val[15];
      default: sign_bit = final_val[31];
    endcase
    if (!zext_q && sign_bit) final_val = final_val | ~byte_mask(n_q);
  end

  // Next-state logic: accept, issue one piece, wait for its response, finish.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    n_d     = n_q;
    k_d     = k_q;
    we_d    = we_q;
    zext_d  = zext_q;
    merge_d = merge_q;
    seen_d  = seen_q;
    err_d   = err_q;
    unal_d  = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_we || bus.i_re) begin
          addr_d  = bus.i_addr;
          sdata_d = bus.i_data;
          n_d     = req_n;
          k_d     = 3'd0;
          we_d    = bus.i_we;
          zext_d  = bus.i_zeroextend;
          merge_d = '0;
          seen_d  = 1'b0;
          if (reject) begin
            err_d   = 1'b1;
            unal_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        seen_d  = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The response is the first idle cycle after the membus went busy.
        if (bus.i_m_stall) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          merge_d = resp_merge;
          k_d     = k_q + plan_size;
          if (bus.i_m_error) err_d = 1'b1;
          if (plan_last || bus.i_m_error) begin
            if (!we_q) rdata_d = final_val;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sdata_q <= '0;
      n_q     <= 3'd4;
      k_q     <= '0;
      we_q    <= 1'b0;
      zext_q  <= 1'b0;
      merge_q <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      unal_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      n_q     <= n_d;
      k_q     <= k_d;
      we_q    <= we_d;
      zext_q  <= zext_d;
      merge_q <= merge_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      unal_q  <= unal_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.o_stall        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign bus.o_data         = rdata_q;
  assign bus.o_error        = err_q;
  assign bus.o_unaligned    = unal_q;
  assign bus.o_m_addr       = cur_addr;
  assign bus.o_m_data       = (sdata_q >> shamt) & piece_mask;
  assign bus.o_m_width      = plan_width;
  assign bus.o_m_we         = (state_q == ST_ISSUE) && we_q;
  assign bus.o_m_re         = (state_q == ST_ISSUE) && !we_q;
  assign bus.o_m_zeroextend = 1'b1;

endmodule

// File: tb/tb_dmembus_unaligned_splitter.sv
// Directed bench: a hand-driven membus responds to each piece with a fixed
// stall pattern; expected values are hand-computed constants.
module tb_dmembus_unaligned_splitter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dmembus_unaligned_splitter_if bus();
  dmembus_unaligned_splitter_if bus2();

  dmembus_unaligned_splitter #(.ENABLE_SPLIT(1'b1), .WRAP_ADDR(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  dmembus_unaligned_splitter #(.ENABLE_SPLIT(1'b1), .WRAP_ADDR(1'b0)) dut_nw (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                     input logic we, input logic zx);
    bus.i_addr = a; bus.i_data = d; bus.i_width = w; bus.i_zeroextend = zx;
    bus.i_we = we; bus.i_re = !we;
    tick();
    bus.i_we = 1'b0; bus.i_re = 1'b0;
  endtask

  // Check the issued piece, then stall two cycles and return rd/re.
  task automatic piece(input string tag, input logic [31:0] ea, input logic [1:0] ew,
                       input logic ewe, input logic [31:0] ed,
                       input logic [31:0] rd, input logic rerr);
    int unsigned n = 0;
    while (!(bus.o_m_we || bus.o_m_re) && n < 8) begin
      tick();
      n++;
    end
    chk({tag, " issued"}, 32'(bus.o_m_we | bus.o_m_re), 32'd1);
    chk({tag, " addr"},   bus.o_m_addr, ea);
    chk({tag, " width"},  32'(bus.o_m_width), 32'(ew));
    chk({tag, " we"},     32'(bus.o_m_we), 32'(ewe));
    chk({tag, " stall"},  32'(bus.o_stall), 32'd1);
    if (ewe) chk({tag, " sdata"}, bus.o_m_data, ed);
    tick();
    bus.i_m_stall = 1'b1;
    tick();
    chk({tag, " no reissue"}, 32'(bus.o_m_we | bus.o_m_re), 32'd0);
    bus.i_m_stall = 1'b0; bus.i_m_data = rd; bus.i_m_error = rerr;
    tick();
    bus.i_m_data = 32'h0; bus.i_m_error = 1'b0;
  endtask

  initial begin
    bus.i_addr = '0; bus.i_data = '0; bus.i_width = 2'b11; bus.i_we = 1'b0;
    bus.i_re = 1'b0; bus.i_zeroextend = 1'b0;
    bus.i_m_data = '0; bus.i_m_stall = 1'b0; bus.i_m_error = 1'b0;
    bus2.i_addr = '0; bus2.i_data = '0; bus2.i_width = 2'b11; bus2.i_we = 1'b0;
    bus2.i_re = 1'b0; bus2.i_zeroextend = 1'b0;
    bus2.i_m_data = '0; bus2.i_m_stall = 1'b0; bus2.i_m_error = 1'b0;

    // reset
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("rst stall", 32'(bus.o_stall), 32'd0);
    chk("rst error", 32'(bus.o_error), 32'd0);
    chk("rst unal",  32'(bus.o_unaligned), 32'd0);
    chk("rst m_we",  32'(bus.o_m_we), 32'd0);
    chk("rst m_re",  32'(bus.o_m_re), 32'd0);
    chk("rst data",  bus.o_data, 32'h0);

    // aligned LW
    req(32'h1000, 32'h0, 2'b11, 1'b0, 1'b0);
    piece("lw p0", 32'h1000, 2'b11, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("lw stall", 32'(bus.o_stall), 32'd0);
    chk("lw data",  bus.o_data, 32'hDEADBEEF);
    chk("lw err",   32'(bus.o_error), 32'd0);
    chk("lw single", 32'(bus.o_m_re), 32'd0);
    tick();

    // SW unaligned: byte, half, byte
    req(32'h1001, 32'h11223344, 2'b11, 1'b1, 1'b0);
    piece("sw p0", 32'h1001, 2'b01, 1'b1, 32'h44,   32'h0, 1'b0);
    piece("sw p1", 32'h1002, 2'b10, 1'b1, 32'h2233, 32'h0, 1'b0);
    piece("sw p2", 32'h1004, 2'b01, 1'b1, 32'h11,   32'h0, 1'b0);
    chk("sw stall", 32'(bus.o_stall), 32'd0);
    chk("sw data hold", bus.o_data, 32'hDEADBEEF);
    chk("sw err", 32'(bus.o_error), 32'd0);
    tick();

    // LH signed across a word boundary
    req(32'h2003, 32'h0, 2'b10, 1'b0, 1'b0);
    piece("lhs p0", 32'h2003, 2'b01, 1'b0, 32'h0, 32'hABCDEF34, 1'b0);
    piece("lhs p1", 32'h2004, 2'b01, 1'b0, 32'h0, 32'h00000092, 1'b0);
    chk("lhs data", bus.o_data, 32'hFFFF9234);
    tick();
    req(32'h2003, 32'h0, 2'b10, 1'b0, 1'b1);
    piece("lhz p0", 32'h2003, 2'b01, 1'b0, 32'h0, 32'h00000034, 1'b0);
    piece("lhz p1", 32'h2004, 2'b01, 1'b0, 32'h0, 32'h00000092, 1'b0);
    chk("lhz data", bus.o_data, 32'h00009234);
    tick();

    // error on the first piece aborts the rest
    req(32'h3002, 32'h0, 2'b11, 1'b0, 1'b0);
    piece("lwe p0", 32'h3002, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("lwe stall", 32'(bus.o_stall), 32'd0);
    chk("lwe err",   32'(bus.o_error), 32'd1);
    chk("lwe no p1", 32'(bus.o_m_re | bus.o_m_we), 32'd0);
    tick();
    chk("lwe idle no p1", 32'(bus.o_m_re | bus.o_m_we), 32'd0);
    chk("lwe err sticky", 32'(bus.o_error), 32'd1);
    req(32'h3000, 32'h0, 2'b01, 1'b0, 1'b0);
    piece("lb p0", 32'h3000, 2'b01, 1'b0, 32'h0, 32'h00000080, 1'b0);
    chk("lb err cleared", 32'(bus.o_error), 32'd0);
    chk("lb data", bus.o_data, 32'hFFFFFF80);
    tick();

    // wrap at the top of the address space
    req(32'hFFFFFFFF, 32'h0, 2'b11, 1'b0, 1'b0);
    piece("wrap p0", 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0, 32'h00000011, 1'b0);
    piece("wrap p1", 32'h00000000, 2'b10, 1'b0, 32'h0, 32'h00003322, 1'b0);
    piece("wrap p2", 32'h00000002, 2'b01, 1'b0, 32'h0, 32'h00000044, 1'b0);
    chk("wrap data", bus.o_data, 32'h44332211);
    chk("wrap err",  32'(bus.o_error), 32'd0);
    tick();

    // no-wrap instance rejects the crossing request
    bus2.i_addr = 32'hFFFFFFFF; bus2.i_width = 2'b11; bus2.i_re = 1'b1;
    tick();
    bus2.i_re = 1'b0;
    chk("nw unal",  32'(bus2.o_unaligned), 32'd1);
    chk("nw err",   32'(bus2.o_error), 32'd1);
    chk("nw stall", 32'(bus2.o_stall), 32'd0);
    chk("nw no piece", 32'(bus2.o_m_re | bus2.o_m_we), 32'd0);
    tick();
    chk("nw unal pulse", 32'(bus2.o_unaligned), 32'd0);
    chk("nw no piece 2", 32'(bus2.o_m_re | bus2.o_m_we), 32'd0);

    // reset while waiting on the second piece
    req(32'h1001, 32'h0, 2'b11, 1'b0, 1'b0);
    piece("rw p0", 32'h1001, 2'b01, 1'b0, 32'h0, 32'h000000AA, 1'b0);
    chk("rw p1 addr", bus.o_m_addr, 32'h1002);
    chk("rw p1 re",   32'(bus.o_m_re), 32'd1);
    tick();
    bus.i_m_stall = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rw stall", 32'(bus.o_stall), 32'd0);
    chk("rw m_re",  32'(bus.o_m_re), 32'd0);
    chk("rw m_we",  32'(bus.o_m_we), 32'd0);
    chk("rw data",  bus.o_data, 32'h0);
    bus.i_m_stall = 1'b0; bus.i_m_data = 32'h00005566;
    tick();
    bus.i_m_data = 32'h0;
    chk("rw late stall", 32'(bus.o_stall), 32'd0);
    chk("rw late m_re",  32'(bus.o_m_re), 32'd0);
    chk("rw late data",  bus.o_data, 32'h0);
    chk("rw late err",   32'(bus.o_error), 32'd0);
    tick();
    chk("rw later m_re", 32'(bus.o_m_re | bus.o_m_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmembus_unaligned_splitter.md
Name: dmembus_unaligned_splitter

Overview:
- Sits directly upstream of the aligned-only data membus, between the CPU memory stage and that membus.
- Accepts load/store requests of any byte alignment and splits each unaligned request into a sequence of legal aligned pieces (word@4n, half@2n, byte@any).
- Issues the pieces to the membus one at a time, merges read bytes, and applies the final sign/zero extension.
- Presents the same stall/data/error request interface upstream, so the core never sees an alignment fault from the membus.

Parameters:
- ENABLE_SPLIT, 1: when 0, unaligned requests are not issued downstream; o_unaligned pulses and the request completes with o_error=1.
- WRAP_ADDR, 1: when 1, piece addresses wrap modulo 2^32; when 0, a request crossing 0xFFFFFFFF is rejected like ENABLE_SPLIT=0.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-low (0 = reset)
- i_addr  in  32  byte address of request
- i_data  in  32  store data, LSB-justified
- i_width  in  2  01 = byte, 10 = half, 11 or 00 = word
- i_we  in  1  store request (1-cycle pulse)
- i_re  in  1  load request (1-cycle pulse)
- i_zeroextend  in  1  1 = zero-extend load, 0 = sign-extend
- o_data  out  32  load result, valid on cycle o_stall falls
- o_stall  out  1  busy
- o_error  out  1  bus error on any piece, valid with completion
- o_unaligned  out  1  1-cycle pulse: request rejected (param-gated)
- o_m_addr  out  32  piece address to membus
- o_m_data  out  32  piece store data, LSB-justified
- o_m_width  out  2  piece width (01/10/11)
- o_m_we  out  1  piece store pulse
- o_m_re  out  1  piece load pulse
- o_m_zeroextend  out  1  always 1 (merge is done here)
- i_m_data  in  32  membus load result
- i_m_stall  in  1  membus busy
- i_m_error  in  1  membus error

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - Outputs: o_stall=0, o_error=0, o_unaligned=0, o_m_we=0, o_m_re=0, o_data=0.
  - FSM returns to IDLE and any in-flight op is abandoned. No further pieces are issued, and a late membus response is ignored.
- Request accept: a request is accepted in IDLE when i_we|i_re. A request while o_stall=1 is illegal; it is ignored and flagged under VERIFICATION.
- Accept registers addr, data, width, we, zeroextend. It also initialises total byte count N (1/2/4), offset k=0 and merge register=0. o_stall=1 from the next cycle.
- FSM states:
  - IDLE -> ISSUE on accept.
  - ISSUE: drive a 1-cycle o_m_we/o_m_re pulse for the current piece -> WAIT.
  - WAIT: i_m_stall rises the cycle after issue. The response cycle is the first WAIT cycle with i_m_stall=0 after it was 1.
    - On response: merge, then k += piece size.
    - If k<N and no error -> ISSUE; else -> DONE.
  - DONE: o_stall=0, o_data=final, o_error=sticky error -> IDLE.
- Piece selection (greedy), with c = addr+k and r = N-k:
  - c[1:0]==0 && r>=4 -> word.
  - else c[0]==0 && r>=2 -> half.
  - else byte.
  - Maximum 3 pieces (e.g. word@..1 = byte, half, byte).
- Aligned requests produce exactly 1 piece.
- Store piece data = stored_data >> (8*k), low piece-width bytes.
- Load merge: merge |= (i_m_data masked to piece width) << (8*k).
- Final load result: merge masked to N bytes, then sign-extended from bit 8N-1 unless zeroextend. Store completion: o_data holds its previous value.
- Errors:
  - Pieces are issued in ascending address order.
  - A piece error aborts the remaining pieces. Earlier store pieces stay committed.
  - o_error=1 at DONE.
  - o_error clears on the next accept.
- Latency: accept at T. The first issue is at T+1. Completion is the DONE cycle after the last response, with no bubble between pieces beyond ISSUE.

Decomposition:
- Shared package dmembus_pkg:
  - Width encodings (WIDTH_BYTE/HALF/WORD).
  - Splitter FSM state enum.
  - Function width_bytes(width) -> 1/2/4.
- One natural sub-module, dmembus_piece_plan (combinational): c[1:0] and r -> piece width, size, and last flag.

Test Plan:
- Aligned LW @0x1000, membus returns 0xDEADBEEF -> exactly 1 word piece; o_data=0xDEADBEEF; o_stall high through completion.
- SW 0x11223344 @0x1001 -> pieces: byte 0x44@0x1001, half 0x2233@0x1002, byte 0x11@0x1004 in order.
- LH signed @0x2003, bytes 0x34@2003 and 0x92@2004 -> 2 byte pieces; o_data=0xFFFF9234. Same request with zeroextend=1 -> 0x00009234.
- LW @0x3002 with i_m_error on piece 1 -> no second piece issued; o_error=1; next aligned request clears o_error.
- LW @0xFFFFFFFF with WRAP_ADDR=1 -> pieces byte@0xFFFFFFFF, half@0x0, byte@0x2. With WRAP_ADDR=0 -> o_unaligned pulse, no piece, o_error=1.
- Reset asserted in WAIT of piece 2 -> o_stall=0 next cycle, no further o_m_we/o_m_re; the late i_m_stall fall produces no output change.
